// File: rtl/fifo_drain.sv
// fifo_drain: reads words from an upstream FIFO into a 2-entry skid buffer
// and streams them downstream as fixed-length bursts.
module fifo_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           words_out,
    output logic                  underflow_err
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic [7:0]            beat_q, beat_d;
    logic [15:0]           words_q, words_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic [2:0]            committed;

    assign pop       = m_valid & m_ready;
    // Slots already spoken for once this cycle's pop leaves.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en    = (state_q == RUN) & ~fifo_empty & (committed < 3'd2);
    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = head_q;
    assign m_last        = m_valid & (beat_q == LAST_BEAT);
    assign busy          = (state_q != IDLE);
    assign words_out     = words_q;
    assign underflow_err = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (!inflight_q && occ_q == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        unique case ({inflight_q, pop})
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) head_d = fifo_data_out;
                else               tail_d = fifo_data_out;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Capture lands behind whatever stays after the pop.
                if (occ_q == 2'd1) begin
                    head_d = fifo_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_d  = beat_q;
        words_d = words_q;
        err_d   = err_q | fifo_underflow;
        if (pop) begin
            beat_d  = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
            words_d = words_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= 8'd0;
            words_q    <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            words_q    <= words_d;
            err_q      <= err_d;
        end
    end
endmodule
